// File: rtl/fifo_pkg.sv
// Purpose: shared FIFO helpers: depth derivation, count width, parameter
//          legality checks and the packed status-flag payload.
// Ports:   none (package).
package fifo_pkg;

    // Number of storage words for a given address width.
    function automatic int unsigned fifo_depth(input int unsigned asize);
        return 32'd1 << asize;
    endfunction

    // Occupancy counter width: must represent 0..DEPTH inclusive.
    function automatic int unsigned fifo_cnt_width(input int unsigned asize);
        return asize + 32'd1;
    endfunction

    // Elaboration-time legality of the parameter set.
    function automatic bit fifo_params_legal(input int unsigned dsize,
                                             input int unsigned asize,
                                             input int unsigned af_level,
                                             input int unsigned ae_level);
        int unsigned depth;
        depth = fifo_depth(asize);
        return (dsize >= 32'd1) && (asize >= 32'd1) && (asize <= 32'd8) &&
               (af_level >= 32'd1) && (af_level <= depth) &&
               (ae_level <= depth - 32'd1);
    endfunction

    // Occupancy-derived status flags, registered together.
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Purpose: producer/consumer bus of the synchronous FIFO.
// Ports:   master drives requests and write data; slave (the FIFO) drives
//          read data, occupancy, status and sticky error flags.
interface sync_fifo_ctrl_if #(
    parameter int unsigned DSIZE = 140,
    parameter int unsigned ASIZE = 2
);
    logic               fifo_w_enable;
    logic               fifo_r_enable;
    logic               fifo_flush;
    logic               err_clr;
    logic [DSIZE-1:0]   data_to_fifo;
    logic [DSIZE-1:0]   data_from_fifo;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_almost_full;
    logic               fifo_almost_empty;
    logic [ASIZE:0]     fifo_count;
    logic               fifo_overflow;
    logic               fifo_underflow;

    modport master (
        output fifo_w_enable, fifo_r_enable, fifo_flush, err_clr, data_to_fifo,
        input  data_from_fifo, fifo_empty, fifo_full, fifo_almost_full,
               fifo_almost_empty, fifo_count, fifo_overflow, fifo_underflow
    );

    modport slave (
        input  fifo_w_enable, fifo_r_enable, fifo_flush, err_clr, data_to_fifo,
        output data_from_fifo, fifo_empty, fifo_full, fifo_almost_full,
               fifo_almost_empty, fifo_count, fifo_overflow, fifo_underflow
    );
endinterface

// File: rtl/fifo_mem_2p.sv
// Purpose: DSIZE x DEPTH register array, one write port, one async read port.
// Ports:   clk_i, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (read).
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = 140,
    parameter int unsigned ASIZE = 2
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic [ASIZE-1:0] raddr_i,
    output logic [DSIZE-1:0] rdata_o
);
    localparam int unsigned DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem_q [DEPTH];

    // Storage has no reset: contents are meaningless until written.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_ctrl.sv
// Purpose: single-clock parametrised FIFO with thresholds, occupancy count,
//          optional first-word-fall-through, flush and sticky error flags.
// Ports:   clk_in, rst_n (async active-low), bus (slave side of
//          sync_fifo_ctrl_if: requests in, data/status out).
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE    = 140,
    parameter int unsigned ASIZE    = 2,
    parameter int unsigned AF_LEVEL = 3,
    parameter int unsigned AE_LEVEL = 1,
    parameter int unsigned FWFT     = 0
) (
    input  logic             clk_in,
    input  logic             rst_n,
    sync_fifo_ctrl_if.slave  bus
);
    localparam int unsigned DEPTH = fifo_depth(ASIZE);
    localparam int unsigned CW    = fifo_cnt_width(ASIZE);

    generate
        if (!fifo_params_legal(DSIZE, ASIZE, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
            $error("sync_fifo_ctrl: illegal DSIZE/ASIZE/AF_LEVEL/AE_LEVEL combination");
        end
    endgenerate

    logic [ASIZE-1:0] wptr_q, wptr_d;
    logic [ASIZE-1:0] rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    fifo_flags_t      flags_q, flags_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [DSIZE-1:0] dout_q, dout_d;

    logic             rd_acc_c;
    logic             wr_acc_c;
    logic [DSIZE-1:0] mem_rdata_c;

    fifo_mem_2p #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk_i   (clk_in),
        .we_i    (wr_acc_c),
        .waddr_i (wptr_q),
        .wdata_i (bus.data_to_fifo),
        .raddr_i (rptr_q),
        .rdata_o (mem_rdata_c)
    );

    // State register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            flags_q <= '{empty: 1'b1, full: 1'b0, almost_empty: 1'b1, almost_full: 1'b0};
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            flags_q <= flags_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            dout_q  <= dout_d;
        end
    end

    // Accept decisions, next pointers/count, flags and error tracking.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;

        // Flush swallows any same-cycle request; a write at full is still
        // accepted when a read frees the slot in the same cycle.
        rd_acc_c = bus.fifo_r_enable & ~flags_q.empty & ~bus.fifo_flush;
        wr_acc_c = bus.fifo_w_enable & (~flags_q.full | rd_acc_c) & ~bus.fifo_flush;

        if (bus.fifo_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc_c) wptr_d = wptr_q + ASIZE'(1);
            if (rd_acc_c) rptr_d = rptr_q + ASIZE'(1);
            unique case ({wr_acc_c, rd_acc_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if ((FWFT == 0) && rd_acc_c) begin
            dout_d = mem_rdata_c;
        end

        // Error set dominates a simultaneous clear.
        ovf_d = (ovf_q & ~bus.err_clr) |
                (bus.fifo_w_enable & flags_q.full & ~rd_acc_c & ~bus.fifo_flush);
        unf_d = (unf_q & ~bus.err_clr) |
                (bus.fifo_r_enable & flags_q.empty & ~bus.fifo_flush);

        flags_d.empty        = (count_d == '0);
        flags_d.full         = (count_d == CW'(DEPTH));
        flags_d.almost_empty = (count_d <= CW'(AE_LEVEL));
        flags_d.almost_full  = (count_d >= CW'(AF_LEVEL));
    end

    assign bus.fifo_count        = count_q;
    assign bus.fifo_empty        = flags_q.empty;
    assign bus.fifo_full         = flags_q.full;
    assign bus.fifo_almost_empty = flags_q.almost_empty;
    assign bus.fifo_almost_full  = flags_q.almost_full;
    assign bus.fifo_overflow     = ovf_q;
    assign bus.fifo_underflow    = unf_q;

    // FWFT presents the head word straight from storage, forced to 0 when empty.
    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_from_fifo = flags_q.empty ? '0 : mem_rdata_c;
        end else begin : g_std
            assign bus.data_from_fifo = dout_q;
        end
    endgenerate
endmodule
